sysbus_arbiter: RTL and testbench

SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

---
 rtl/sysbus_arbiter.sv | 148 ++++++++++++++
 tb/tb_sysbus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// Two-requester (ifetch / dmem) round-robin arbiter onto a single-outstanding line bus.
// Latency: grant one cycle after request; DONE one cycle after the last beat, then one idle cycle.
// Backpressure: address/write beats held until bus_reqack; read beats accepted on every bus_respcyc.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      c0_req,
    input  logic                      c0_write,
    input  logic [BUS_DATA_WIDTH-1:0] c0_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_tag,
    input  logic [BUS_DATA_WIDTH-1:0] c0_wdata,
    output logic                      c0_grant,
    output logic                      c0_wdata_ack,
    output logic                      c0_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp_data,
    output logic                      c0_done,

    input  logic                      c1_req,
    input  logic                      c1_write,
    input  logic [BUS_DATA_WIDTH-1:0] c1_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_tag,
    input  logic [BUS_DATA_WIDTH-1:0] c1_wdata,
    output logic                      c1_grant,
    output logic                      c1_wdata_ack,
    output logic                      c1_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp_data,
    output logic                      c1_done,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RESP, DONE} state_t;

    state_t                    state;
    logic                      owner;
    logic                      own_write;
    logic [BUS_DATA_WIDTH-1:0] own_addr;
    logic [BUS_TAG_WIDTH-1:0]  own_tag;
    logic                      last_grant;
    logic [CW-1:0]             beat_cnt;
    logic [1:0]                grant_q;
    logic [1:0]                done_q;

    logic pick;
    logic last_beat;
    logic unused_resptag;

    // Tie goes to whoever was not served last; otherwise the sole requester wins.
    assign pick      = c1_req & (~c0_req | ~last_grant);
    assign last_beat = (beat_cnt == CW'(BEATS - 1));

    // Routing follows the latched owner, never the returned tag.
    assign unused_resptag = ^bus_resptag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            own_write  <= 1'b0;
            own_addr   <= '0;
            own_tag    <= '0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            grant_q    <= '0;
            done_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        state     <= ADDR;
                        owner     <= pick;
                        own_write <= pick ? c1_write : c0_write;
                        own_addr  <= pick ? c1_addr : c0_addr;
                        own_tag   <= pick ? c1_tag : c0_tag;
                        beat_cnt  <= '0;
                        grant_q   <= pick ? 2'b10 : 2'b01;
                    end
                end
                ADDR: begin
                    if (bus_reqack)
                        state <= own_write ? WDATA : RESP;
                end
                WDATA, RESP: begin
                    if ((state == WDATA) ? bus_reqack : bus_respcyc) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (last_beat) begin
                            state   <= DONE;
                            grant_q <= '0;
                            done_q  <= owner ? 2'b10 : 2'b01;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done_q     <= '0;
                    last_grant <= owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic addr_ph;
    logic wr_ph;
    logic rd_beat;

    assign addr_ph = (state == ADDR);
    assign wr_ph   = (state == WDATA);
    assign rd_beat = (state == RESP) && bus_respcyc;

    always_comb begin
        bus_req = '0;
        if (addr_ph)
            bus_req = own_addr;
        else if (wr_ph)
            bus_req = owner ? c1_wdata : c0_wdata;
    end

    assign bus_reqcyc  = addr_ph | wr_ph;
    assign bus_reqtag  = (addr_ph | wr_ph) ? own_tag : '0;
    assign bus_respack = rd_beat;

    assign c0_grant      = grant_q[0];
    assign c1_grant      = grant_q[1];
    assign c0_done       = done_q[0];
    assign c1_done       = done_q[1];
    assign c0_wdata_ack  = wr_ph & bus_reqack & ~owner;
    assign c1_wdata_ack  = wr_ph & bus_reqack & owner;
    assign c0_resp_valid = rd_beat & ~owner;
    assign c1_resp_valid = rd_beat & owner;
    assign c0_resp_data  = c0_resp_valid ? bus_resp : '0;
    assign c1_resp_data  = c1_resp_valid ? bus_resp : '0;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: transaction-level model checked every cycle, directed scenarios, random traffic.
// Latency: model advances once per clock; inputs driven 1 time unit after the rising edge.
// Backpressure: bus ack/response cadence is driven directly by the bench.
module tb_sysbus_arbiter;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          c0_req = 0, c0_write = 0, c1_req = 0, c1_write = 0;
    logic [DW-1:0] c0_addr = '0, c0_wdata = '0, c1_addr = '0, c1_wdata = '0;
    logic [TW-1:0] c0_tag = '0, c1_tag = '0;
    logic          c0_grant, c0_wdata_ack, c0_resp_valid, c0_done;
    logic          c1_grant, c1_wdata_ack, c1_resp_valid, c1_done;
    logic [DW-1:0] c0_resp_data, c1_resp_data;
    logic          bus_reqcyc, bus_respack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack = 0, bus_respcyc = 0;
    logic [DW-1:0] bus_resp = '0;
    logic [TW-1:0] bus_resptag = '0;

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_write(c0_write), .c0_addr(c0_addr), .c0_tag(c0_tag), .c0_wdata(c0_wdata),
        .c0_grant(c0_grant), .c0_wdata_ack(c0_wdata_ack), .c0_resp_valid(c0_resp_valid),
        .c0_resp_data(c0_resp_data), .c0_done(c0_done),
        .c1_req(c1_req), .c1_write(c1_write), .c1_addr(c1_addr), .c1_tag(c1_tag), .c1_wdata(c1_wdata),
        .c1_grant(c1_grant), .c1_wdata_ack(c1_wdata_ack), .c1_resp_valid(c1_resp_valid),
        .c1_resp_data(c1_resp_data), .c1_done(c1_done),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Transaction-level reference: one in-flight transfer described by owner, phase flags and beat count.
    bit            m_busy = 0, m_apend = 0, m_done = 0, m_write = 0;
    int            m_own = 0, m_beats = 0, m_last = 1;
    logic [DW-1:0] m_addr = '0;
    logic [TW-1:0] m_tag = '0;

    // Observed-event bookkeeping used by the directed scenarios.
    int            rv_cnt[2] = '{0, 0}, wack_cnt[2] = '{0, 0}, done_cnt[2] = '{0, 0}, last_rv_cyc[2] = '{0, 0};
    logic [DW-1:0] rv_sum[2] = '{64'd0, 64'd0};
    logic [DW-1:0] wack_sum = '0;
    int            respack_cnt = 0, reqcyc_cnt = 0;
    int            gl_who[$], gl_cyc[$], dl_who[$], dl_cyc[$];
    logic [1:0]    prev_g = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [1:0]    eg, ed, ew, ev, g, d, w, v;
        logic [DW-1:0] ereq;
        logic [TW-1:0] etag;
        logic          ereqcyc, eack;
        bit            tagchk;
        int            win;
        @(negedge clk);
        cyc++;
        eg = '0; ed = '0; ew = '0; ev = '0; ereq = '0; etag = '0; ereqcyc = 0; eack = 0; tagchk = 1;
        if (m_busy && m_done) begin
            ed[m_own] = 1'b1;
        end else if (m_busy) begin
            eg[m_own] = 1'b1;
            if (m_apend) begin
                ereqcyc = 1; ereq = m_addr; etag = m_tag;
            end else if (m_write) begin
                ereqcyc = 1; ereq = (m_own == 1) ? c1_wdata : c0_wdata; ew[m_own] = bus_reqack; tagchk = 0;
            end else begin
                eack = bus_respcyc; ev[m_own] = bus_respcyc;
            end
        end
        g = {c1_grant, c0_grant}; d = {c1_done, c0_done};
        w = {c1_wdata_ack, c0_wdata_ack}; v = {c1_resp_valid, c0_resp_valid};
        chk("grant", g, eg);
        chk("done", d, ed);
        chk("wdata_ack", w, ew);
        chk("resp_valid", v, ev);
        chk("bus_reqcyc", bus_reqcyc, ereqcyc);
        chk("bus_req", bus_req, ereq);
        if (tagchk) chk("bus_reqtag", bus_reqtag, etag);
        chk("bus_respack", bus_respack, eack);
        if (ev[0] || !m_busy) chk("c0_resp_data", c0_resp_data, ev[0] ? bus_resp : '0);
        if (ev[1] || !m_busy) chk("c1_resp_data", c1_resp_data, ev[1] ? bus_resp : '0);

        for (int n = 0; n < 2; n++) begin
            if (g[n] && !prev_g[n]) begin gl_who.push_back(n); gl_cyc.push_back(cyc); end
            if (d[n]) begin done_cnt[n]++; dl_who.push_back(n); dl_cyc.push_back(cyc); end
            if (v[n]) begin
                rv_cnt[n]++; last_rv_cyc[n] = cyc;
                rv_sum[n] = rv_sum[n] + ((n == 1) ? c1_resp_data : c0_resp_data);
            end
            if (w[n]) begin wack_cnt[n]++; wack_sum = wack_sum + bus_req; end
        end
        prev_g = g;
        if (bus_respack) respack_cnt++;
        if (bus_reqcyc) reqcyc_cnt++;

        if (reset) begin
            m_busy = 0; m_apend = 0; m_done = 0; m_beats = 0; m_last = 1;
        end else if (m_done) begin
            m_done = 0; m_busy = 0; m_last = m_own;
        end else if (!m_busy) begin
            if (c0_req || c1_req) begin
                win = (c0_req && c1_req) ? 1 - m_last : (c1_req ? 1 : 0);
                m_own = win; m_busy = 1; m_apend = 1; m_beats = 0;
                m_addr  = win ? c1_addr : c0_addr;
                m_tag   = win ? c1_tag : c0_tag;
                m_write = win ? c1_write : c0_write;
            end
        end else if (m_apend) begin
            if (bus_reqack) m_apend = 0;
        end else if (m_write ? bus_reqack : bus_respcyc) begin
            m_beats++;
            if (m_beats == NB) m_done = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_c0_flags"}, {c0_grant, c0_wdata_ack, c0_resp_valid, c0_done}, 0);
        chk({tag, "_c1_flags"}, {c1_grant, c1_wdata_ack, c1_resp_valid, c1_done}, 0);
        chk({tag, "_resp_data"}, c0_resp_data | c1_resp_data, 0);
        chk({tag, "_bus_flags"}, {bus_reqcyc, bus_respack}, 0);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_reqtag"}, bus_reqtag, 0);
    endtask

    initial begin
        int s_rv0, s_rv1, s_sum0, s_rp, s_rc, s_d0, s_d1, s_w0, s_w1, i0, d0, beat;
        logic [DW-1:0] s_ws;
        bit pat[10];

        // Reset state
        tick(); tick();
        check_zero("reset");
        reset = 0;
        tick();

        // Single read by c0, address ack on the third ADDR cycle, beats 0..7
        s_rv0 = rv_cnt[0]; s_rv1 = rv_cnt[1]; s_sum0 = int'(rv_sum[0]); s_rp = respack_cnt;
        s_rc = reqcyc_cnt; s_d0 = done_cnt[0];
        c0_req = 1; c0_write = 0; c0_addr = 64'h1000; c0_tag = 13'h5;
        tick();
        c0_req = 0; c0_addr = 64'hBAD0; bus_reqack = 0;
        tick(); tick();
        bus_reqack = 1; tick();
        bus_reqack = 0;
        for (int i = 0; i < NB; i++) begin
            bus_respcyc = 1; bus_resp = 64'(i); tick();
        end
        bus_respcyc = 0; tick(); tick();
        chk("rd_addr_cycles", reqcyc_cnt - s_rc, 3);
        chk("rd_beats_c0", rv_cnt[0] - s_rv0, 8);
        chk("rd_beats_c1", rv_cnt[1] - s_rv1, 0);
        chk("rd_data_sum", int'(rv_sum[0]) - s_sum0, 28);
        chk("rd_respack", respack_cnt - s_rp, 8);
        chk("rd_done", done_cnt[0] - s_d0, 1);
        chk("rd_done_lag", dl_cyc[dl_cyc.size() - 1] - last_rv_cyc[0], 1);

        // Tie right after reset: c0 first, c1 two cycles after c0_done
        reset = 1; tick(); reset = 0;
        i0 = gl_who.size(); d0 = dl_who.size();
        c0_req = 1; c1_req = 1; c0_write = 0; c1_write = 0;
        c0_addr = 64'h100; c1_addr = 64'h200; c0_tag = 13'h11; c1_tag = 13'h22;
        bus_reqack = 1; bus_respcyc = 1;
        for (int i = 0; i < 22; i++) begin bus_resp = 64'(i); tick(); end
        c0_req = 0; c1_req = 0;
        for (int i = 0; i < 14; i++) tick();
        bus_reqack = 0; bus_respcyc = 0;
        chk("tie_enough_grants", (gl_who.size() - i0 >= 2) && (dl_who.size() > d0), 1);
        if ((gl_who.size() - i0 >= 2) && (dl_who.size() > d0)) begin
            chk("tie_first", gl_who[i0], 0);
            chk("tie_second", gl_who[i0 + 1], 1);
            chk("tie_gap", gl_cyc[i0 + 1] - dl_cyc[d0], 2);
        end

        // Write burst by c1 with a two-cycle ack stall mid-burst
        s_w0 = wack_cnt[0]; s_w1 = wack_cnt[1]; s_ws = wack_sum; s_rp = respack_cnt;
        s_d1 = done_cnt[1]; s_rc = reqcyc_cnt;
        pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        c1_req = 1; c1_write = 1; c1_addr = 64'h2000; c1_tag = 13'h77;
        tick();
        c1_req = 0; c1_addr = 64'hDEAD; c1_tag = 13'h0; bus_reqack = 1;
        tick();
        beat = 0;
        for (int k = 0; k < 10; k++) begin
            bus_reqack = pat[k]; c1_wdata = 64'hA0 + 64'(beat);
            tick();
            if (pat[k]) beat++;
        end
        bus_reqack = 0; tick(); tick();
        chk("wr_acks_c1", wack_cnt[1] - s_w1, 8);
        chk("wr_acks_c0", wack_cnt[0] - s_w0, 0);
        chk("wr_data_sum", wack_sum - s_ws, 64'h51C);
        chk("wr_no_resp", respack_cnt - s_rp, 0);
        chk("wr_done", done_cnt[1] - s_d1, 1);
        chk("wr_reqcyc_cycles", reqcyc_cnt - s_rc, 11);

        // Stray response while idle
        s_rp = respack_cnt; s_rv0 = rv_cnt[0]; s_rv1 = rv_cnt[1];
        bus_respcyc = 1;
        for (int i = 0; i < 3; i++) begin bus_resp = 64'hF00 + 64'(i); tick(); end
        bus_respcyc = 0;
        chk("stray_respack", respack_cnt - s_rp, 0);
        chk("stray_rv", (rv_cnt[0] - s_rv0) + (rv_cnt[1] - s_rv1), 0);

        // Reset after three read beats, then a clean c1 read
        s_rv0 = rv_cnt[0]; s_rv1 = rv_cnt[1]; s_d0 = done_cnt[0]; s_d1 = done_cnt[1];
        c0_req = 1; c0_write = 0; c0_addr = 64'h3000;
        tick();
        c0_req = 0; bus_reqack = 1; tick();
        bus_reqack = 0;
        for (int i = 0; i < 3; i++) begin bus_respcyc = 1; bus_resp = 64'h30 + 64'(i); tick(); end
        bus_respcyc = 0; reset = 1; tick();
        check_zero("midrst");
        reset = 0; bus_respcyc = 1; tick(); tick();
        bus_respcyc = 0;
        c1_req = 1; c1_write = 0; c1_addr = 64'h4000; tick();
        c1_req = 0; bus_reqack = 1; tick();
        bus_reqack = 0;
        for (int i = 0; i < NB; i++) begin bus_respcyc = 1; bus_resp = 64'h40 + 64'(i); tick(); end
        bus_respcyc = 0; tick(); tick();
        chk("midrst_c0_beats", rv_cnt[0] - s_rv0, 3);
        chk("midrst_c0_done", done_cnt[0] - s_d0, 0);
        chk("midrst_c1_beats", rv_cnt[1] - s_rv1, 8);
        chk("midrst_c1_done", done_cnt[1] - s_d1, 1);

        // Random traffic, every cycle checked against the model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(399) == 0);
            c0_req      = ($urandom_range(99) < 30);
            c1_req      = ($urandom_range(99) < 30);
            c0_write    = $urandom_range(1);
            c1_write    = $urandom_range(1);
            c0_addr     = {$urandom, $urandom};
            c1_addr     = {$urandom, $urandom};
            c0_tag      = TW'($urandom);
            c1_tag      = TW'($urandom);
            c0_wdata    = {$urandom, $urandom};
            c1_wdata    = {$urandom, $urandom};
            bus_reqack  = ($urandom_range(99) < 60);
            bus_respcyc = ($urandom_range(99) < 60);
            bus_resp    = {$urandom, $urandom};
            bus_resptag = TW'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
